uart_tx_port: RTL and testbench
===============================

UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 Parameter TX_DATA_PORT, default 16'h0000: port ID whose write loads a transmit byte.
REQ-002 Parameter STATUS_PORT, default 16'h0001: port ID whose read returns the status word.
REQ-003 Parameter BAUD_DIV, default 5208: CLK cycles per serial bit, legal range 2..65535.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 PORT_ID  input  16  port address from the processor port bus.
REQ-007 OUT_PORT  input  16  processor write data; only bits [7:0] are used.
REQ-008 WRITE_STROBE  input  1  one-cycle processor write qualifier.
REQ-009 READ_STROBE  input  1  one-cycle processor read qualifier.
REQ-010 INTERRUPT_ACK  input  1  processor interrupt acknowledge.
REQ-011 READ_DATA  output  16  read data for the processor IN_PORT mux.
REQ-012 TX  output  1  serial line, idle high.
REQ-013 TX_BUSY  output  1  high while a frame is in progress.
REQ-014 INTERRUPT  output  1  frame-complete interrupt request, level, held until acknowledged.

Function
REQ-015 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-016 The FSM SHALL have the states IDLE, START, DATA and STOP, and SHALL reset to IDLE.
REQ-017 In IDLE, when WRITE_STROBE=1 and PORT_ID==TX_DATA_PORT, the block SHALL latch OUT_PORT[7:0] into the shift register and enter START on the same edge.
REQ-018 TX SHALL be a registered output, and SHALL fall in the first cycle after the accepting edge.
REQ-019 TX_BUSY SHALL be 1 in that same first cycle.
REQ-020 Each bit SHALL last exactly BAUD_DIV cycles, timed by a baud counter reloaded at each bit boundary.
REQ-021 A complete frame SHALL last exactly 10*BAUD_DIV cycles.
REQ-022 DATA SHALL use a 3-bit bit counter counting 0..7; the transition to STOP SHALL occur after bit 7 completes.
REQ-023 At the end of the stop bit the FSM SHALL return to IDLE, and TX_BUSY SHALL fall on that edge.
REQ-024 On the same edge as REQ-023, INTERRUPT SHALL be set to 1.
REQ-025 A write to TX_DATA_PORT while not in IDLE SHALL be ignored entirely: no data change and no frame restart.
REQ-026 A write accepted in the first IDLE cycle after a frame SHALL start the next frame with no added idle gap beyond that cycle.
REQ-027 INTERRUPT SHALL clear on the edge after INTERRUPT_ACK=1.
REQ-028 If INTERRUPT is set and acknowledged on the same edge, the set SHALL win and INTERRUPT SHALL remain 1.
REQ-029 When PORT_ID==STATUS_PORT, READ_DATA SHALL be combinational and equal {13'b0, INTERRUPT, ~TX_BUSY, TX_BUSY}.
REQ-030 For any other PORT_ID, READ_DATA SHALL be 16'h0000, so it can be OR-combined with other peripherals.
REQ-031 READ_STROBE SHALL have no side effects; reading status SHALL NOT clear INTERRUPT.
REQ-032 Writes whose PORT_ID matches neither port SHALL have no effect.
REQ-033 A write to STATUS_PORT SHALL have no effect.

Reset
REQ-034 While RESET=1 at a rising edge: TX=1, TX_BUSY=0, INTERRUPT=0, state IDLE, baud counter, bit counter and shift register all zero.
REQ-035 RESET SHALL take priority over all other inputs, including a simultaneous write strobe.
REQ-036 RESET asserted mid-frame SHALL abort the frame, with TX=1 from the next cycle.
REQ-037 A frame aborted by reset SHALL NOT set INTERRUPT.

Verification (BAUD_DIV=4)
REQ-038 Write 16'h00A5 to port 0 -> TX carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; TX_BUSY is high for 40 cycles; INTERRUPT rises on the 40th edge after acceptance.
REQ-039 Second write of 16'h00FF issued 8 cycles into the A5 frame -> ignored; the A5 frame completes unchanged.
REQ-040 Read port 1 mid-frame -> READ_DATA=16'h0001. Read port 1 after the frame, before acknowledge -> 16'h0006. Read port 1 after INTERRUPT_ACK -> 16'h0002.
REQ-041 INTERRUPT_ACK pulsed on the edge where the frame ends -> INTERRUPT stays 1. A later ACK pulse -> INTERRUPT=0 on the following cycle.
REQ-042 RESET pulsed at cycle 15 of a frame -> TX=1, TX_BUSY=0 and INTERRUPT=0 next cycle. A new write of 16'h0055 afterwards -> a correct full frame.
REQ-043 Back-to-back test: write 16'h0001 in the first IDLE cycle after a frame -> new start bit in the following cycle; PORT_ID=16'h0002 -> READ_DATA=16'h0000.

Source files
------------

// File: rtl/uart_tx_port.sv
// Port-mapped 8N1 UART transmitter for a processor port bus.
// A write to TX_DATA_PORT starts a frame; STATUS_PORT reads busy/idle/interrupt flags.
module uart_tx_port #(
    parameter logic [15:0] TX_DATA_PORT = 16'h0000,
    parameter logic [15:0] STATUS_PORT  = 16'h0001,
    parameter int unsigned BAUD_DIV     = 5208
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] PORT_ID,
    input  logic [15:0] OUT_PORT,
    input  logic        WRITE_STROBE,
    input  logic        READ_STROBE,
    input  logic        INTERRUPT_ACK,
    output logic [15:0] READ_DATA,
    output logic        TX,
    output logic        TX_BUSY,
    output logic        INTERRUPT
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        intr_q, intr_d;
    logic        bit_end;
    logic        intr_set;
    logic        tx_write;

    assign bit_end  = (baud_cnt_q == BaudLast);
    assign tx_write = WRITE_STROBE && (PORT_ID == TX_DATA_PORT);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        intr_set   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_write) begin
                    state_d    = StStart;
                    shift_d    = OUT_PORT[7:0];
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d    = StData;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    shift_d    = {1'b0, shift_q[7:1]};
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = StStop;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d    = StIdle;
                    baud_cnt_d = '0;
                    intr_set   = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame completion beats a coincident acknowledge.
        intr_d = intr_set | (intr_q & ~INTERRUPT_ACK);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            intr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            intr_q     <= intr_d;
        end
    end

    assign TX        = tx_q;
    assign TX_BUSY   = (state_q != StIdle);
    assign INTERRUPT = intr_q;

    // Zero when not addressed so the bus can OR peripherals together.
    assign READ_DATA = (PORT_ID == STATUS_PORT) ? {13'b0, intr_q, ~TX_BUSY, TX_BUSY} : 16'h0000;

    logic unused_inputs;
    assign unused_inputs = ^{OUT_PORT[15:8], READ_STROBE};

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port (BAUD_DIV=4): directed vector table, corner-case sequences and
// random traffic, all checked against a frame-timeline reference model.
module tb_uart_tx_port;

    localparam int BD = 4;
    localparam int FRAME = 10 * BD;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] PORT_ID = '0;
    logic [15:0] OUT_PORT = '0;
    logic        WRITE_STROBE = 1'b0;
    logic        READ_STROBE = 1'b0;
    logic        INTERRUPT_ACK = 1'b0;
    logic [15:0] READ_DATA;
    logic        TX;
    logic        TX_BUSY;
    logic        INTERRUPT;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: whether a frame is running, cycles since acceptance, its byte, irq flag.
    logic       m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_data = '0;
    logic       m_intr = 1'b0;

    uart_tx_port #(
        .TX_DATA_PORT(16'h0000),
        .STATUS_PORT (16'h0001),
        .BAUD_DIV    (BD)
    ) dut (
        .CLK          (clk),
        .RESET        (RESET),
        .PORT_ID      (PORT_ID),
        .OUT_PORT     (OUT_PORT),
        .WRITE_STROBE (WRITE_STROBE),
        .READ_STROBE  (READ_STROBE),
        .INTERRUPT_ACK(INTERRUPT_ACK),
        .READ_DATA    (READ_DATA),
        .TX           (TX),
        .TX_BUSY      (TX_BUSY),
        .INTERRUPT    (INTERRUPT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] port;
        logic [15:0] data;
        logic        wr;
        logic        ack;
        logic        e_tx;
        logic        e_busy;
        logic        e_intr;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return d[idx-1];
    endfunction

    task automatic model_step(input logic r, input logic [15:0] p, input logic [15:0] d,
                              input logic w, input logic a);
        logic done;
        logic acc;
        if (r) begin
            m_active = 1'b0;
            m_t      = 0;
            m_intr   = 1'b0;
        end else begin
            done = m_active && (m_t == FRAME - 1);
            acc  = !m_active && w && (p == 16'h0000);
            if (m_active) begin
                m_t++;
                if (done) m_active = 1'b0;
            end
            if (acc) begin
                m_active = 1'b1;
                m_t      = 0;
                m_data   = d[7:0];
            end
            if (done) m_intr = 1'b1;
            else if (a) m_intr = 1'b0;
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] p, input logic [15:0] d,
                         input logic w, input logic rs, input logic a);
        RESET         = r;
        PORT_ID       = p;
        OUT_PORT      = d;
        WRITE_STROBE  = w;
        READ_STROBE   = rs;
        INTERRUPT_ACK = a;
        @(posedge clk);
        model_step(r, p, d, w, a);
        #1;
    endtask

    // One clock with inputs applied, then compare all outputs against the model.
    task automatic cycle(input logic r, input logic [15:0] p, input logic [15:0] d,
                         input logic w, input logic rs, input logic a);
        logic        e_tx;
        logic [15:0] e_rd;
        drive(r, p, d, w, rs, a);
        e_tx = m_active ? frame_bit(m_data, m_t / BD) : 1'b1;
        e_rd = (p == 16'h0001) ? {13'b0, m_intr, ~m_active, m_active} : 16'h0000;
        check("tx", {15'b0, TX}, {15'b0, e_tx});
        check("busy", {15'b0, TX_BUSY}, {15'b0, m_active});
        check("intr", {15'b0, INTERRUPT}, {15'b0, m_intr});
        check("read_data", READ_DATA, e_rd);
    endtask

    initial begin
        logic [9:0] got_bits;
        int         busy_cnt;
        logic       r;
        logic       w;

        // rst, port, data, wr, ack | tx, busy, intr, read_data
        vecs[0]  = '{1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
        vecs[1]  = '{1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 16'h0001, 16'h00AA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
        vecs[3]  = '{1'b0, 16'h0005, 16'h0033, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0100, 16'h0033, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 16'h0000, 16'h00A5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
        vecs[7]  = '{1'b0, 16'h0000, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001};
        vecs[9]  = '{1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
        vecs[10] = '{1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].port, vecs[i].data, vecs[i].wr, 1'b0, vecs[i].ack);
            check($sformatf("vec%0d_tx", i), {15'b0, TX}, {15'b0, vecs[i].e_tx});
            check($sformatf("vec%0d_busy", i), {15'b0, TX_BUSY}, {15'b0, vecs[i].e_busy});
            check($sformatf("vec%0d_intr", i), {15'b0, INTERRUPT}, {15'b0, vecs[i].e_intr});
            check($sformatf("vec%0d_rd", i), READ_DATA, vecs[i].e_rd);
        end

        // A5 frame with ignored mid-frame write, status reads, ack coinciding with frame end.
        got_bits = '0;
        busy_cnt = 0;
        cycle(1'b0, 16'h0000, 16'h00A5, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 45; k++) begin
            if (k > 0) begin
                cycle(1'b0, (k == 9) ? 16'h0000 : 16'h0001, 16'h00FF, (k == 9), 1'b1,
                      (k == 40) || (k == 44));
            end
            if (TX_BUSY) busy_cnt++;
            if ((k % BD) == 2 && k < FRAME) got_bits[k/BD] = TX;
            if (k == 41) check("status_after_frame", READ_DATA, 16'h0006);
            if (k == 45) check("status_after_ack", READ_DATA, 16'h0002);
        end
        check("a5_bits", {6'b0, got_bits}, {6'b0, 10'b1101001010});
        check("a5_busy_cycles", 16'(busy_cnt), 16'(FRAME));

        // Back-to-back: second write in the first idle cycle after a frame.
        cycle(1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++) cycle(1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("b2b_idle_gap", {15'b0, TX_BUSY}, 16'h0000);
        cycle(1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0);
        check("b2b_start_bit", {15'b0, TX}, 16'h0000);
        for (int k = 1; k <= 42; k++) cycle(1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, k == 42);

        // Reset 15 cycles into a frame, then a clean 0x55 frame.
        cycle(1'b0, 16'h0000, 16'h003C, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) cycle(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("abort_tx", {15'b0, TX}, 16'h0001);
        for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("abort_no_intr", {15'b0, INTERRUPT}, 16'h0000);
        cycle(1'b0, 16'h0000, 16'h0055, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 44; k++) cycle(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 3) == 0);
            cycle(r, 16'($urandom_range(0, 2)), 16'($urandom), w, 1'($urandom),
                  ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
